ats21_host: RTL
===============

ATS21_HOST -- requirements
Module: ats21_host

Interface
REQ-001 Parameter: NUM_ALARMS, 24, alarm vector width and ATS21 data width.
REQ-002 Parameter: TIMEOUT_CYCLES, 64, max cycles req is held without ready before abort (>=2).
REQ-003 Port: clk  in  1  single clock; all logic on posedge.
REQ-004 Port: reset  in  1  synchronous, active-high reset.
REQ-005 Port: cmd_valid  in  1  upstream command present.
REQ-006 Port: cmd_ready  out  1  host accepts command this cycle.
REQ-007 Port: cmd_a  in  16  command word for ctrlA.
REQ-008 Port: cmd_b  in  16  command word for ctrlB.
REQ-009 Port: rsp_valid  out  1  one-cycle response strobe.
REQ-010 Port: rsp_stat  out  2  response status.
REQ-011 Port: rsp_data  out  24  response payload.
REQ-012 Port: req  out  1  request to ATS21.
REQ-013 Port: ctrlA  out  16  ATS21 control word A.
REQ-014 Port: ctrlB  out  16  ATS21 control word B.
REQ-015 Port: ready  in  1  ATS21 completion strobe.
REQ-016 Port: stat  in  2  ATS21 status, valid when ready=1.
REQ-017 Port: data  in  24  ATS21 payload when ready=1; alarm-finished vector when ready=0.
REQ-018 Port: alarm_clr  in  24  write-1-to-clear for alarm_pending.
REQ-019 Port: alarm_pending  out  24  sticky per-alarm finished flags.
REQ-020 Port: alarm_irq  out  1  OR-reduction of alarm_pending.

Function
REQ-021 FSM states SHALL be IDLE, REQ, RESP, GAP; only IDLE asserts cmd_ready.
REQ-022 IDLE with cmd_valid=1 SHALL capture cmd_a/cmd_b, zero the timeout counter, enter REQ next cycle.
REQ-023 In REQ, req=1 and ctrlA/ctrlB SHALL equal captured words, stable every cycle until exit.
REQ-024 REQ with ready=1 SHALL capture stat/data and enter RESP; req drops the following cycle.
REQ-025 REQ SHALL abort to RESP with captured stat=2'b11, data=0 when ready is still 0 on the TIMEOUT_CYCLES-th REQ cycle; ready in that same cycle wins over timeout.
REQ-026 RESP SHALL assert rsp_valid for exactly one cycle with captured stat/data; no backpressure.
REQ-027 GAP SHALL hold req=0 one cycle, then return to IDLE, guaranteeing req low >=1 cycle between commands.
REQ-028 Latency: command accepted cycle N -> req high N+1; ready at cycle M -> rsp_valid at M+1; min command-to-command spacing 4 cycles.
REQ-029 ctrlA/ctrlB SHALL drive 0 whenever req=0.
REQ-030 rsp_stat/rsp_data SHALL be 0 when rsp_valid=0.
REQ-031 Alarm sampling SHALL occur only in cycles with ready=0; previous-sample register holds through ready=1 cycles.
REQ-032 Rising edge (sample=1, previous=0) on bit i SHALL set alarm_pending[i] next cycle.
REQ-033 Set and alarm_clr on the same bit in the same cycle: set SHALL win.
REQ-034 alarm_irq SHALL be combinational OR of registered alarm_pending.
REQ-035 ready=1 outside REQ SHALL be ignored for responses (no rsp_valid, no state change).

Reset
REQ-036 Reset SHALL force IDLE, req=0, ctrlA=ctrlB=0, rsp_valid=0, rsp_stat=0, rsp_data=0, alarm_pending=0, previous-sample=0, counter=0, cmd_ready=0 during reset cycle.
REQ-037 Reset mid-REQ SHALL drop req the next cycle and discard the in-flight command with no rsp_valid.

Structure
REQ-038 ats21_pkg SHALL hold the FSM state enum, stat codes (OK 2'b00, ERR 2'b01, BUSY 2'b10, TIMEOUT 2'b11) and NUM_ALARMS default.
REQ-039 Alarm sampling/edge/sticky logic SHALL be sub-module ats21_alarm_monitor; timeout counter width $clog2(TIMEOUT_CYCLES)+1.

Verification
REQ-040 cmd_a=16'h8001, cmd_b=16'h0005, ready pulses 3rd REQ cycle with stat=00, data=24'h000123 -> rsp_valid one cycle later, rsp_stat=00, rsp_data=24'h000123.
REQ-041 Responder never asserts ready, TIMEOUT_CYCLES=8 -> req high exactly 8 cycles, then rsp_stat=11, rsp_data=0.
REQ-042 data=24'h000004 with ready=0 -> alarm_pending[2]=1, alarm_irq=1; alarm_clr=24'h000004 -> both 0 next cycle.
REQ-043 data bit 5 rises while alarm_clr[5]=1 -> alarm_pending[5] stays 1.
REQ-044 Back-to-back cmd_valid held high -> req deasserted >=1 cycle between commands, ctrlA/ctrlB constant during each req.
REQ-045 reset asserted on 2nd REQ cycle -> req=0 next cycle, no rsp_valid, all outputs zero.

Source files
------------

// File: rtl/ats21_pkg.sv
// ats21_pkg: shared FSM state encoding, ATS21 status codes and default sizing.
package ats21_pkg;
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2,
        ST_GAP  = 2'd3
    } state_t;
    localparam logic [1:0] STAT_OK      = 2'b00;
    localparam logic [1:0] STAT_ERR     = 2'b01;
    localparam logic [1:0] STAT_BUSY    = 2'b10;
    localparam logic [1:0] STAT_TIMEOUT = 2'b11;
    localparam int NUM_ALARMS_DEF = 24;
endpackage

// File: rtl/ats21_alarm_monitor.sv
// ats21_alarm_monitor: samples the alarm vector while ready is low and keeps sticky rising-edge flags.
module ats21_alarm_monitor import ats21_pkg::*; #(
    parameter int W = NUM_ALARMS_DEF
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         ready,
    input  logic [W-1:0] data,
    input  logic [W-1:0] alarm_clr,
    output logic [W-1:0] alarm_pending,
    output logic         alarm_irq
);
    logic [W-1:0] prev;
    logic [W-1:0] rise;
    // data carries a payload while ready is high, so those cycles are not alarm samples
    assign rise = ready ? '0 : (data & ~prev);
    assign alarm_irq = |alarm_pending;
    always_ff @(posedge clk) begin
        if (reset) begin
            prev          <= '0;
            alarm_pending <= '0;
        end else begin
            prev          <= ready ? prev : data;
            alarm_pending <= (alarm_pending & ~alarm_clr) | rise;
        end
    end
endmodule

// File: rtl/ats21_host.sv
// ats21_host: single-outstanding command host for the ATS21 req/ready handshake with timeout abort
// and an alarm-finished monitor.
module ats21_host import ats21_pkg::*; #(
    parameter int NUM_ALARMS     = NUM_ALARMS_DEF,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [15:0]           cmd_a,
    input  logic [15:0]           cmd_b,
    output logic                  rsp_valid,
    output logic [1:0]            rsp_stat,
    output logic [NUM_ALARMS-1:0] rsp_data,
    output logic                  req,
    output logic [15:0]           ctrlA,
    output logic [15:0]           ctrlB,
    input  logic                  ready,
    input  logic [1:0]            stat,
    input  logic [NUM_ALARMS-1:0] data,
    input  logic [NUM_ALARMS-1:0] alarm_clr,
    output logic [NUM_ALARMS-1:0] alarm_pending,
    output logic                  alarm_irq
);
    localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    state_t                  state;
    logic [15:0]             a_q, b_q;
    logic [CW-1:0]           cnt;
    logic [1:0]              stat_q;
    logic [NUM_ALARMS-1:0]   data_q;

    assign cmd_ready = (state == ST_IDLE) & ~reset;
    assign req       = state == ST_REQ;
    assign ctrlA     = req ? a_q : '0;
    assign ctrlB     = req ? b_q : '0;
    assign rsp_valid = state == ST_RESP;
    assign rsp_stat  = rsp_valid ? stat_q : '0;
    assign rsp_data  = rsp_valid ? data_q : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= ST_IDLE;
            a_q    <= '0;
            b_q    <= '0;
            cnt    <= '0;
            stat_q <= STAT_OK;
            data_q <= '0;
        end else begin
            case (state)
                ST_IDLE: if (cmd_valid) begin
                    a_q   <= cmd_a;
                    b_q   <= cmd_b;
                    cnt   <= '0;
                    state <= ST_REQ;
                end
                ST_REQ: begin
                    // a completion in the final allowed cycle still beats the timeout
                    if (ready) begin
                        stat_q <= stat;
                        data_q <= data;
                        state  <= ST_RESP;
                    end else if (cnt == LAST) begin
                        stat_q <= STAT_TIMEOUT;
                        data_q <= '0;
                        state  <= ST_RESP;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                ST_RESP: state <= ST_GAP;
                default: state <= ST_IDLE;
            endcase
        end
    end

    ats21_alarm_monitor #(.W(NUM_ALARMS)) u_alarm (
        .clk          (clk),
        .reset        (reset),
        .ready        (ready),
        .data         (data),
        .alarm_clr    (alarm_clr),
        .alarm_pending(alarm_pending),
        .alarm_irq    (alarm_irq)
    );
endmodule
